// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_pkg
//  Description : Shared AXI4 types for the slave RAM: burst encodings,
//                response codes and the write/read FSM state typedefs.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    // 2'b11 is the reserved burst encoding; a burst using it is answered with SLVERR.
    localparam logic [1:0] c_burst_rsvd  = 2'b11;

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

endpackage
`default_nettype wire

// File: rtl/axi_slave_ram_mem.sv
`default_nettype none
// ============================================================================
//  Module      : axi_slave_ram_mem
//  Description : DEPTH_WORDS x DATA_WIDTH storage array with one byte-enabled
//                write port and one registered read port. A read and a write
//                to the same word in the same cycle return the old contents.
//  Ports       : clk, rst_n          - clock, async active-low reset (read reg only)
//                i_we/i_waddr/i_wdata/i_wstrb - write port
//                i_re/i_raddr/o_rdata          - read port, data one cycle after i_re
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_slave_ram_mem #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0]          i_wdata,
    input  logic [DATA_WIDTH/8-1:0]        i_wstrb,
    input  logic                           i_re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0]          o_rdata
);

    localparam int c_nb = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Array has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < c_nb; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Non-blocking update of the array means this samples pre-write data on collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/axi_slave_ram.sv
`default_nettype none
// ============================================================================
//  Module      : axi_slave_ram
//  Description : AXI4 slave backed by an on-chip RAM. Independent write and
//                read FSMs, one outstanding burst each. FIXED/INCR/WRAP bursts
//                all step the word address modulo DEPTH_WORDS (WRAP behaves as
//                INCR, FIXED holds). Reserved burst type, WLAST mismatch and
//                out-of-range start address give SLVERR; out-of-range bursts
//                do not write and read back zero.
//  Ports       : ACLK, ARESETn      - clock, async active-low reset
//                s_axi_aw*/w*/b*    - AXI4 write address/data/response channels
//                s_axi_ar*/r*       - AXI4 read address/data channels
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_slave_ram
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_WIDTH  = 32,
    parameter int ID_WIDTH    = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    // write address
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic                    s_axi_awuser,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    // write data
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wuser,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    // write response
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_buser,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    // read address
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic                    s_axi_aruser,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    // read data
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_ruser,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int c_lsb = $clog2(DATA_WIDTH / 8);
    localparam int c_aw  = $clog2(DEPTH_WORDS);

    // Sideband fields with no effect on this slave.
    logic w_unused;
    assign w_unused = &{1'b0, s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                        s_axi_awqos, s_axi_awuser, s_axi_wuser, s_axi_arsize, s_axi_arlock,
                        s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_aruser};

    // ---------------------------------------------------------------- write path
    wstate_e               r_wstate;
    logic [c_aw-1:0]       r_waddr;
    logic [7:0]            r_wlen;
    logic [7:0]            r_wcnt;
    logic [1:0]            r_wburst;
    logic                  r_woor;
    logic                  r_werr;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic [ID_WIDTH-1:0]   r_bid;

    logic w_aw_hs, w_w_hs, w_aw_oor, w_wlast_exp, w_wlast_bad;

    assign w_aw_hs     = r_awready & s_axi_awvalid;
    assign w_w_hs      = r_wready & s_axi_wvalid;
    // Any address bit above the array's byte span means out of range.
    assign w_aw_oor    = (s_axi_awaddr >> (c_lsb + c_aw)) != '0;
    assign w_wlast_exp = (r_wcnt == r_wlen);
    assign w_wlast_bad = (s_axi_wlast != w_wlast_exp);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wstate  <= W_IDLE;
            r_waddr   <= '0;
            r_wlen    <= '0;
            r_wcnt    <= '0;
            r_wburst  <= '0;
            r_woor    <= 1'b0;
            r_werr    <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_resp_okay;
            r_bid     <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_waddr   <= s_axi_awaddr[c_lsb +: c_aw];
                        r_wlen    <= s_axi_awlen;
                        r_wcnt    <= '0;
                        r_wburst  <= s_axi_awburst;
                        r_bid     <= s_axi_awid;
                        r_woor    <= w_aw_oor;
                        r_werr    <= (s_axi_awburst == c_burst_rsvd);
                        r_wstate  <= W_DATA;
                    end else begin
                        // First edge out of reset raises AWREADY.
                        r_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        if (w_wlast_bad) r_werr <= 1'b1;
                        if (r_wburst != BURST_FIXED) r_waddr <= r_waddr + 1'b1;
                        r_wcnt <= r_wcnt + 8'd1;
                        if (w_wlast_exp) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || w_wlast_bad || r_woor) ? c_resp_slverr
                                                                          : c_resp_okay;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // ----------------------------------------------------------------- read path
    rstate_e               r_rstate;
    logic [c_aw-1:0]       r_raddr;
    logic [7:0]            r_rlen;
    logic [7:0]            r_rcnt;
    logic [1:0]            r_rburst;
    logic                  r_roor;
    logic                  r_arready;
    logic                  r_rvalid;
    logic                  r_rlast;
    logic [1:0]            r_rresp;
    logic [ID_WIDTH-1:0]   r_rid;

    logic                  w_ar_hs, w_r_hs, w_ar_oor, w_mem_re;
    logic [c_aw-1:0]       w_raddr_next, w_mem_raddr;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    assign w_ar_hs      = r_arready & s_axi_arvalid;
    assign w_r_hs       = r_rvalid & s_axi_rready;
    assign w_ar_oor     = (s_axi_araddr >> (c_lsb + c_aw)) != '0;
    assign w_raddr_next = (r_rburst == BURST_FIXED) ? r_raddr : r_raddr + 1'b1;
    // The RAM read register only loads on AR accept or on a non-last beat
    // handshake, so RDATA holds while the master stalls.
    assign w_mem_re     = w_ar_hs | (w_r_hs & ~r_rlast);
    assign w_mem_raddr  = w_ar_hs ? s_axi_araddr[c_lsb +: c_aw] : w_raddr_next;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rstate  <= R_IDLE;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
            r_rburst  <= '0;
            r_roor    <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= c_resp_okay;
            r_rid     <= '0;
        end else if (r_rstate == R_IDLE) begin
            if (w_ar_hs) begin
                r_arready <= 1'b0;
                r_rvalid  <= 1'b1;
                r_raddr   <= s_axi_araddr[c_lsb +: c_aw];
                r_rlen    <= s_axi_arlen;
                r_rcnt    <= '0;
                r_rburst  <= s_axi_arburst;
                r_rid     <= s_axi_arid;
                r_roor    <= w_ar_oor;
                r_rlast   <= (s_axi_arlen == 8'd0);
                r_rresp   <= (w_ar_oor || s_axi_arburst == c_burst_rsvd) ? c_resp_slverr
                                                                         : c_resp_okay;
                r_rstate  <= R_DATA;
            end else begin
                r_arready <= 1'b1;
            end
        end else if (w_r_hs) begin
            if (r_rlast) begin
                r_rvalid  <= 1'b0;
                r_rlast   <= 1'b0;
                r_arready <= 1'b1;
                r_rstate  <= R_IDLE;
            end else begin
                r_raddr <= w_raddr_next;
                r_rcnt  <= r_rcnt + 8'd1;
                r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
            end
        end
    end

    // ---------------------------------------------------------------- storage
    axi_slave_ram_mem #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_mem (
        .clk     (ACLK),
        .rst_n   (ARESETn),
        .i_we    (w_w_hs & ~r_woor),
        .i_waddr (r_waddr),
        .i_wdata (s_axi_wdata),
        .i_wstrb (s_axi_wstrb),
        .i_re    (w_mem_re),
        .i_raddr (w_mem_raddr),
        .o_rdata (w_mem_rdata)
    );

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bid     = r_bid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_buser   = 1'b0;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_arready = r_arready;
    assign s_axi_rid     = r_rid;
    assign s_axi_rdata   = r_roor ? '0 : w_mem_rdata;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_ruser   = 1'b0;
    assign s_axi_rvalid  = r_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_slave_ram
//  Description : Directed self-checking bench for axi_slave_ram. Expected
//                write responses and read beats are queued when a transaction
//                is issued and compared as the slave returns them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_slave_ram;

    localparam int DW = 32;
    localparam int DEPTH = 1024;
    localparam int IDW = 4;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, RSVD = 2'b11;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [IDW-1:0] awid, arid, bid, rid;
    logic [31:0]    awaddr, araddr;
    logic [7:0]     awlen, arlen;
    logic [1:0]     awburst, arburst, bresp, rresp;
    logic           awvalid, awready, wvalid, wready, wlast, bvalid, bready, buser;
    logic           arvalid, arready, rvalid, rready, rlast, ruser;
    logic [DW-1:0]  wdata, rdata;
    logic [3:0]     wstrb;

    axi_slave_ram #(.DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .ADDR_WIDTH(32), .ID_WIDTH(IDW)) dut (
        .ACLK(clk), .ARESETn(rst_n),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(3'd2),
        .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
        .s_axi_awqos(4'd0), .s_axi_awuser(1'b0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wuser(1'b0),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_buser(buser), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(3'd2),
        .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
        .s_axi_arqos(4'd0), .s_axi_aruser(1'b0), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_ruser(ruser), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rexp_t;

    rexp_t       exp_r[$];
    logic [5:0]  exp_b[$];          // {bresp, bid}
    logic [31:0] rd_log[$];
    logic [31:0] model [DEPTH];
    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Called at #1 after a rising edge; returns at the same phase.
    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [3:0] id, input int bad_beat);
        logic [9:0] a;
        logic       oor;
        logic [5:0] bexp;
        int         n;
        a   = addr[11:2];
        oor = (addr >= 32'h1000);
        awaddr = addr; awlen = len; awburst = burst; awid = id; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin @(posedge clk); #1; n++; end
        chk("aw_ready", awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wbuf[i]; wstrb = sbuf[i];
            wlast = (i == int'(len)) ^ (i == bad_beat);
            wvalid = 1'b1;
            n = 0;
            while (!wready && n < 100) begin @(posedge clk); #1; n++; end
            chk("w_ready", wready, 1);
            @(posedge clk); #1;
            if (!oor)
                for (int b = 0; b < 4; b++)
                    if (sbuf[i][b]) model[a][b*8 +: 8] = wbuf[i][b*8 +: 8];
            if (burst != FIXED) a = a + 10'd1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 100) begin @(posedge clk); #1; n++; end
        chk("b_valid", bvalid, 1);
        bexp = exp_b.pop_front();
        chk("b_resp", bresp, bexp[5:4]);
        chk("b_id", bid, bexp[3:0]);
        @(posedge clk); #1;
        bready = 1'b0;
        chk("b_drop", bvalid, 0);
    endtask

    task automatic ar_issue(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [3:0] id);
        logic [9:0] a;
        logic       oor;
        rexp_t      e;
        int         n;
        a   = addr[11:2];
        oor = (addr >= 32'h1000);
        for (int i = 0; i <= int'(len); i++) begin
            e.data = oor ? 32'h0 : model[a];
            e.resp = (oor || burst == RSVD) ? SLVERR : OKAY;
            e.last = (i == int'(len));
            e.id   = id;
            exp_r.push_back(e);
            if (burst != FIXED) a = a + 10'd1;
        end
        araddr = addr; arlen = len; arburst = burst; arid = id; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin @(posedge clk); #1; n++; end
        chk("ar_ready", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("r_first_valid", rvalid, 1);
    endtask

    task automatic r_collect(input int nbeats, input bit stall);
        int          got = 0;
        int          cyc = 0;
        bit          tog = 1'b0;
        bit          held;
        logic [38:0] snap;
        rexp_t       e;
        rd_log.delete();
        while (got < nbeats && cyc < 500) begin
            rready = stall ? tog : 1'b1;
            tog    = !tog;
            held   = rvalid && !rready;
            snap   = {rdata, rresp, rlast, rid};
            if (rvalid && rready) begin
                e = exp_r.pop_front();
                chk("r_data", rdata, e.data);
                chk("r_resp", rresp, e.resp);
                chk("r_last", rlast, e.last);
                chk("r_id", rid, e.id);
                rd_log.push_back(rdata);
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (held) begin
                chk("r_hold_valid", rvalid, 1);
                chk("r_hold_stable", {rdata, rresp, rlast, rid}, snap);
            end
        end
        rready = 1'b0;
        chk("r_beats", got, nbeats);
    endtask

    initial begin
        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_bid", bid, 0);
        chk("rst_rid", rid, 0);
        chk("rst_rdata", rdata, 0);
        chk("tie_user", {buser, ruser}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_awready", awready, 1);
        chk("rel_arready", arready, 1);

        // INCR burst of 4 then read back
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
        exp_b.push_back({OKAY, 4'h5});
        axi_write(32'h10, 8'd3, INCR, 4'h5, -1);
        ar_issue(32'h10, 8'd3, INCR, 4'h6);
        r_collect(4, 1'b0);
        chk("incr_beat4", rd_log[3], 32'h4);
        chk("r_idle_after", rvalid, 0);

        // Byte strobes
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'hF;
        exp_b.push_back({OKAY, 4'h1});
        axi_write(32'h0, 8'd0, INCR, 4'h1, -1);
        wbuf[0] = 32'h11223344; sbuf[0] = 4'b0101;
        exp_b.push_back({OKAY, 4'h2});
        axi_write(32'h0, 8'd0, INCR, 4'h2, -1);
        ar_issue(32'h0, 8'd0, INCR, 4'h2);
        r_collect(1, 1'b0);
        chk("strb_merge", rd_log[0], 32'hAA22CC44);

        // 8-beat read with RREADY toggling
        for (int i = 0; i < 8; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
        exp_b.push_back({OKAY, 4'h3});
        axi_write(32'h100, 8'd7, INCR, 4'h3, -1);
        ar_issue(32'h100, 8'd7, INCR, 4'h7);
        r_collect(8, 1'b1);

        // Error responses
        wbuf[0] = 32'h55550000; wbuf[1] = 32'h55550001; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        exp_b.push_back({SLVERR, 4'h8});
        axi_write(32'h40, 8'd1, INCR, 4'h8, 0);
        wbuf[0] = 32'hDEADBEEF;
        exp_b.push_back({SLVERR, 4'h9});
        axi_write(32'h1000, 8'd0, INCR, 4'h9, -1);
        ar_issue(32'h0, 8'd0, INCR, 4'h1);
        r_collect(1, 1'b0);
        chk("oor_no_write", rd_log[0], 32'hAA22CC44);
        ar_issue(32'h1000, 8'd1, INCR, 4'hA);
        r_collect(2, 1'b0);
        exp_b.push_back({SLVERR, 4'hB});
        axi_write(32'h80, 8'd0, RSVD, 4'hB, -1);

        // Address wrap past the top of memory, then FIXED burst
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + 32'(i); sbuf[i] = 4'hF; end
        exp_b.push_back({OKAY, 4'hC});
        axi_write(32'hFF8, 8'd3, INCR, 4'hC, -1);
        ar_issue(32'hFF8, 8'd1, INCR, 4'h0);
        r_collect(2, 1'b0);
        chk("wrap_w1022", rd_log[0], 32'hA0);
        chk("wrap_w1023", rd_log[1], 32'hA1);
        ar_issue(32'h0, 8'd1, INCR, 4'h0);
        r_collect(2, 1'b0);
        chk("wrap_w0", rd_log[0], 32'hA2);
        chk("wrap_w1", rd_log[1], 32'hA3);
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hF0 + 32'(i); sbuf[i] = 4'hF; end
        exp_b.push_back({OKAY, 4'hD});
        axi_write(32'h200, 8'd3, FIXED, 4'hD, -1);
        ar_issue(32'h200, 8'd0, INCR, 4'h0);
        r_collect(1, 1'b0);
        chk("fixed_last", rd_log[0], 32'hF3);

        // Reset during beat 2 of an 8-beat read
        ar_issue(32'h100, 8'd7, INCR, 4'hD);
        r_collect(1, 1'b0);
        chk("abort_pre_valid", rvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_rvalid", rvalid, 0);
        chk("abort_rlast", rlast, 0);
        chk("abort_rdata", rdata, 0);
        exp_r.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_arready", arready, 1);
        chk("abort_awready", awready, 1);
        ar_issue(32'h100, 8'd7, INCR, 4'hE);
        r_collect(8, 1'b0);
        chk("post_reset_idle", rvalid, 0);
        chk("sb_empty", 64'(exp_r.size() + exp_b.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_slave_ram.md
AXI_SLAVE_RAM -- requirements
Module: axi_slave_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data bus width in bits, a multiple of 8.
REQ-002 Parameter DEPTH_WORDS, default 1024: memory depth in DATA_WIDTH words, a power of 2.
REQ-003 ACLK  input  1  single clock; all logic is rising-edge.
REQ-004 ARESETn  input  1  asynchronous active-low reset.
REQ-005 s_axi  interface  AXI4_FULL.SLAVE  all five AXI4 channels; the block drives AWREADY, WREADY, BID, BRESP, BUSER, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RUSER, RVALID.
REQ-006 BUSER and RUSER SHALL be tied to 0; AWLOCK, AWCACHE, AWPROT, AWQOS, AWUSER and the AR equivalents SHALL be ignored.

Function
REQ-007 Write and read paths SHALL be independent FSMs, each with one outstanding burst.
REQ-008 Write FSM states SHALL be W_IDLE, W_DATA and W_RESP; AWREADY=1 only in W_IDLE, WREADY=1 only in W_DATA, BVALID=1 only in W_RESP.
REQ-009 On AWVALID&&AWREADY, the block SHALL latch word address AWADDR[..log2(DATA_WIDTH/8)], AWLEN, AWID and AWBURST, and go to W_DATA.
REQ-010 Each W beat SHALL write the bytes enabled by WSTRB at the current word, and an INCR or WRAP burst SHALL then advance the word address by 1 modulo DEPTH_WORDS; a FIXED burst SHALL hold the address.
REQ-011 The write burst SHALL end on beat AWLEN+1 (beat counter == AWLEN) and then go to W_RESP; BID SHALL equal the latched AWID.
REQ-012 BRESP SHALL be SLVERR (2'b10) if the WLAST value mismatches at any beat, if AWBURST==2'b11, or if the start address is at or above DEPTH_WORDS*DATA_WIDTH/8; otherwise BRESP SHALL be OKAY.
REQ-013 If the start address is out of range, all writes of that burst SHALL be suppressed.
REQ-014 On BVALID&&BREADY the write FSM SHALL return to W_IDLE; BVALID SHALL hold until accepted.
REQ-015 Read FSM states SHALL be R_IDLE and R_DATA; ARREADY=1 only in R_IDLE.
REQ-016 On ARVALID&&ARREADY the block SHALL latch the AR fields the same way as AW; the first beat SHALL have RVALID=1 on the next cycle.
REQ-017 RDATA SHALL be registered from the current word; on RVALID&&RREADY of a non-last beat, the next beat SHALL be valid on the following cycle, giving back-to-back throughput.
REQ-018 RLAST SHALL be 1 only on beat ARLEN+1, and RID SHALL equal the latched ARID.
REQ-019 RRESP SHALL be SLVERR on every beat under the same conditions as REQ-012, with RDATA=0 for an out-of-range start; otherwise RRESP SHALL be OKAY.
REQ-020 On the RLAST handshake the read FSM SHALL return to R_IDLE; RVALID, RDATA, RLAST and RRESP SHALL hold stable while RREADY=0.
REQ-021 AWSIZE and ARSIZE SHALL be ignored; every beat SHALL be full width.
REQ-022 A read and a write to the same word in the same cycle SHALL return the pre-write data.
REQ-023 When AWLEN=0 or ARLEN=0, the burst SHALL be a single beat with WLAST/RLAST expected on that beat.

Reset
REQ-024 While ARESETn=0: both FSMs SHALL be idle; AWREADY, WREADY, BVALID, ARREADY, RVALID and RLAST SHALL be 0; BRESP, RRESP, BID, RID and RDATA SHALL be 0.
REQ-025 AWREADY and ARREADY SHALL be registered and rise on the first ACLK edge after ARESETn deasserts.
REQ-026 Reset asserted mid-burst SHALL abort the burst immediately, and memory contents SHALL NOT be cleared.

Structure
REQ-027 Package axi_pkg SHALL hold the burst enum (FIXED=0, INCR=1, WRAP=2), the resp constants (OKAY=0, SLVERR=2) and the write/read state typedefs.
REQ-028 Sub-module axi_slave_ram_mem SHALL be a DEPTH_WORDS x DATA_WIDTH array with one byte-enabled write port and one read port that reads old data on collision.

Verification
REQ-029 AW addr 0x10, len 3, INCR, WDATA 1..4, all WSTRB=1, then AR same -> BRESP OKAY, BID echoes AWID, RDATA 1,2,3,4, RLAST on the 4th beat only.
REQ-030 Write 0xAABBCCDD to 0x0, then write 0x11223344 with WSTRB=4'b0101 -> read returns 0xAA22CC44.
REQ-031 Read len 7 with RREADY toggling every cycle -> 8 beats, data stable while stalled, no beat lost or duplicated.
REQ-032 Write len 1 with WLAST on beat 1 -> BRESP SLVERR; a later write to address 0x1000 (DEPTH 1024) -> SLVERR and memory unchanged.
REQ-033 INCR burst starting at word 1022, len 3 -> writes land at words 1022, 1023, 0, 1; a FIXED len 3 burst -> only the last data remains at its address.
REQ-034 ARESETn pulsed low during beat 2 of an 8-beat read -> RVALID=0 at once; after release ARREADY=1 and a new read returns the previously written data.
